// File: rtl/mem_bus_pkg.sv
// Shared definitions for the load/store bus responder: access sizes, FSM states
// and the access fault rule.
package mem_bus_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Reserved size, misaligned half/word, or address beyond the array.
    function automatic logic access_fault(input logic [1:0]  size,
                                          input logic [31:0] addr,
                                          input int unsigned addr_w);
        logic f;
        f = 1'b0;
        if (size == 2'b11) f = 1'b1;
        if (size == SZ_HALF && addr[0]) f = 1'b1;
        if (size == SZ_WORD && addr[1:0] != 2'b00) f = 1'b1;
        if ((addr >> addr_w) != '0) f = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/mem_byte_lanes.sv
// Big-endian byte-lane steering: write mask/data placement and read alignment.
// Mask bit i selects byte offset i, which lives in bits [31-8i -: 8].
module mem_byte_lanes
    import mem_bus_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_word,
    output logic [3:0]  wmask,
    output logic [31:0] wlane,
    output logic [31:0] rdata
);

    logic [4:0] shamt;

    always_comb begin
        wmask = '0;
        wlane = '0;
        rdata = '0;
        shamt = {~offset, 3'b000};
        case (size)
            SZ_WORD: begin
                wmask = 4'b1111;
                wlane = wdata;
                rdata = rd_word;
            end
            SZ_HALF: begin
                if (offset[1]) begin
                    wmask = 4'b1100;
                    wlane = {16'h0, wdata[15:0]};
                    rdata = {16'h0, rd_word[15:0]};
                end else begin
                    wmask = 4'b0011;
                    wlane = {wdata[15:0], 16'h0};
                    rdata = {16'h0, rd_word[31:16]};
                end
            end
            SZ_BYTE: begin
                wmask = 4'b0001 << offset;
                wlane = {24'h0, wdata[7:0]} << shamt;
                rdata = {24'h0, 8'(rd_word >> shamt)};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, programmable wait states,
// big-endian byte array with word/half/byte access and fault reporting.
module mem_responder
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    state_t      state_q, next_state;
    logic [3:0]  cnt_q, cnt_next;
    logic        we_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic        ack_q, err_q, busy_q;

    logic [7:0]  mem [2**ADDR_W];
    logic [31:0] rd_word, rd_aligned, wlane;
    logic [3:0]  wmask;
    logic        capture, cur_fault;

    assign capture = (state_q == IDLE) && req;

    // In IDLE the request being captured is still on the inputs, so the
    // registered err for a zero-wait access must be judged from them.
    assign cur_fault = (state_q == IDLE) ? access_fault(size, addr, ADDR_W)
                                         : access_fault(size_q, addr_q, ADDR_W);

    always_comb begin
        next_state = state_q;
        cnt_next   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES > 0) begin
                        next_state = WAIT;
                        cnt_next   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        next_state = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) next_state = RESP;
                else             cnt_next   = cnt_q - 4'd1;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= next_state;
            cnt_q   <= cnt_next;
            if (capture) begin
                we_q    <= we;
                size_q  <= size;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            ack_q  <= (next_state == RESP);
            err_q  <= (next_state == RESP) && cur_fault;
            busy_q <= (next_state != IDLE);
        end
    end

    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < 4; i++)
            rd_word[31-8*i -: 8] = mem[{addr_q[ADDR_W-1:2], 2'(i)}];
    end

    mem_byte_lanes u_lanes (
        .size   (size_q),
        .offset (addr_q[1:0]),
        .wdata  (wdata_q),
        .rd_word(rd_word),
        .wmask  (wmask),
        .wlane  (wlane),
        .rdata  (rd_aligned)
    );

    // Array is not reset; an async reset forces IDLE so a pending write is dropped.
    always_ff @(posedge clk) begin
        if (state_q == RESP && we_q && !err_q) begin
            for (int unsigned i = 0; i < 4; i++)
                if (wmask[i]) mem[{addr_q[ADDR_W-1:2], 2'(i)}] <= wlane[31-8*i -: 8];
        end
    end

    assign rdata = (state_q == RESP && !we_q && !err_q) ? rd_aligned : '0;
    assign ack   = ack_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a 2-wait-state instance for data/fault/reset
// scenarios and a zero-wait instance for back-to-back throughput.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [1:0]  size = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        ack, err, busy;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [1:0]  size0 = '0;
    logic [31:0] addr0 = '0, wdata0 = '0;
    logic [31:0] rdata0;
    logic        ack0, err0, busy0;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
    );

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .size(size0), .addr(addr0),
        .wdata(wdata0), .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one request on dut, return cycles to ack (capture edge = 1) and response.
    task automatic do_access(input logic w, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] d, output int cyc, output logic [31:0] rd,
                             output logic e);
        cyc = 0; rd = 'x; e = 1'bx;
        @(negedge clk);
        req = 1'b1; we = w; size = sz; addr = a; wdata = d;
        @(posedge clk); #1 req = 1'b0;
        for (int i = 1; i <= 20 && cyc == 0; i++) begin
            @(negedge clk);
            if (ack) begin cyc = i; rd = rdata; e = err; end
            else @(posedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if ({ack, err, busy, rdata} !== 35'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got ack=%b err=%b busy=%b rdata=%h, want all 0", ack, err, busy, rdata);
        end
        tests_run++;
        if ({ack0, err0, busy0, rdata0} !== 35'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs0: got ack=%b err=%b busy=%b rdata=%h, want all 0", ack0, err0, busy0, rdata0);
        end
        reset = 1'b1;
    endtask

    task automatic test_word();
        int cyc; logic [31:0] rd; logic e;
        do_access(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, cyc, rd, e);
        tests_run++;
        if (cyc !== 3 || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL word_write: got latency=%0d err=%b, want 3/0", cyc, e);
        end
        do_access(1'b0, 2'b00, 32'h10, 32'h0, cyc, rd, e);
        tests_run++;
        if (cyc !== 3 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL word_read: got latency=%0d err=%b rdata=%h, want 3/0/deadbeef", cyc, e, rd);
        end
    endtask

    task automatic test_subword();
        int cyc; logic [31:0] rd; logic e;
        do_access(1'b1, 2'b10, 32'h12, 32'h55, cyc, rd, e);
        do_access(1'b0, 2'b01, 32'h12, 32'h0, cyc, rd, e);
        tests_run++;
        if (e !== 1'b0 || rd !== 32'h000055EF) begin
            tests_failed++;
            $display("FAIL half_read: got err=%b rdata=%h, want 0/000055ef", e, rd);
        end
        do_access(1'b0, 2'b00, 32'h10, 32'h0, cyc, rd, e);
        tests_run++;
        if (e !== 1'b0 || rd !== 32'hDEAD55EF) begin
            tests_failed++;
            $display("FAIL word_after_byte: got err=%b rdata=%h, want 0/dead55ef", e, rd);
        end
        do_access(1'b0, 2'b10, 32'h11, 32'h0, cyc, rd, e);
        tests_run++;
        if (e !== 1'b0 || rd !== 32'h000000AD) begin
            tests_failed++;
            $display("FAIL byte_read: got err=%b rdata=%h, want 0/000000ad", e, rd);
        end
        // Highest in-range word, then its last byte.
        do_access(1'b1, 2'b00, 32'hFC, 32'h01020304, cyc, rd, e);
        do_access(1'b0, 2'b10, 32'hFF, 32'h0, cyc, rd, e);
        tests_run++;
        if (e !== 1'b0 || rd !== 32'h00000004) begin
            tests_failed++;
            $display("FAIL top_byte_read: got err=%b rdata=%h, want 0/00000004", e, rd);
        end
    endtask

    task automatic test_faults();
        int cyc; logic [31:0] rd; logic e;
        logic        fw [5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [1:0]  fs [5]  = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b00};
        logic [31:0] fa [5]  = '{32'h11, 32'h13, 32'h10, 32'h100, 32'h110};
        for (int i = 0; i < 5; i++) begin
            do_access(fw[i], fs[i], fa[i], 32'h00000000, cyc, rd, e);
            tests_run++;
            if (cyc !== 3 || e !== 1'b1 || rd !== 32'h0) begin
                tests_failed++;
                $display("FAIL fault_%0d: got latency=%0d err=%b rdata=%h, want 3/1/00000000", i, cyc, e, rd);
            end
        end
        do_access(1'b0, 2'b00, 32'h10, 32'h0, cyc, rd, e);
        tests_run++;
        if (e !== 1'b0 || rd !== 32'hDEAD55EF) begin
            tests_failed++;
            $display("FAIL fault_no_write: got err=%b rdata=%h, want 0/dead55ef", e, rd);
        end
    endtask

    task automatic test_req_while_busy();
        int acks = 0, busy_low = 0, cyc;
        logic [31:0] rd = '0; logic e;
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b00; addr = 32'h10;
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h14; wdata = 32'h0;
        if (!busy) busy_low++;
        @(posedge clk); #1 req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (acks == 0 && !busy) busy_low++;
            if (ack) begin acks++; rd = rdata; end
        end
        tests_run++;
        if (acks !== 1 || rd !== 32'hDEAD55EF) begin
            tests_failed++;
            $display("FAIL busy_ignore_ack: got acks=%0d rdata=%h, want 1/dead55ef", acks, rd);
        end
        tests_run++;
        if (busy_low !== 0) begin
            tests_failed++;
            $display("FAIL busy_held: got %0d low samples before ack, want 0", busy_low);
        end
        // The ignored request was a word write of 0 to 0x10's neighbour 0x14; check 0x10 too.
        do_access(1'b0, 2'b00, 32'h10, 32'h0, cyc, rd, e);
        tests_run++;
        if (rd !== 32'hDEAD55EF) begin
            tests_failed++;
            $display("FAIL busy_ignore_data: got rdata=%h, want dead55ef", rd);
        end
    endtask

    task automatic test_reset_abort();
        int cyc; logic [31:0] rd; logic e;
        do_access(1'b1, 2'b00, 32'h20, 32'h00000000, cyc, rd, e);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h20; wdata = 32'hFFFFFFFF;
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_busy_before: got busy=%b, want 1", busy);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if ({ack, err, busy, rdata} !== 35'h0) begin
            tests_failed++;
            $display("FAIL abort_async: got ack=%b err=%b busy=%b rdata=%h, want all 0", ack, err, busy, rdata);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        do_access(1'b0, 2'b00, 32'h20, 32'h0, cyc, rd, e);
        tests_run++;
        if (e !== 1'b0 || rd !== 32'h00000000) begin
            tests_failed++;
            $display("FAIL abort_no_write: got err=%b rdata=%h, want 0/00000000", e, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic exp;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; size0 = 2'b00; addr0 = 32'h0;
        #1;
        tests_run++;
        if (ack0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_no_comb_ack: got ack=%b, want 0", ack0);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp = (i % 2 == 0);
            tests_run++;
            if (ack0 !== exp || busy0 !== exp || err0 !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_cycle_%0d: got ack=%b busy=%b err=%b, want %b/%b/0", i, ack0, busy0, err0, exp, exp);
            end
        end
        req0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_faults();
        test_req_while_busy();
        test_reset_abort();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
